// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: holds the PC and IR, issues single-beat instruction
// memory reads, and decodes the IR fields.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_go,
  input  logic        PC_ld,
  input  logic [1:0]  PC_sel,
  input  logic [31:0] PC_In,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic        im_cs,
  output logic        im_rd,
  output logic [31:0] im_addr,
  output logic [31:0] PC_Out,
  output logic [31:0] IR_Out,
  output logic        IR_valid,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [31:0] SE_16,
  output logic        busy,
  output logic        fault
);

  // state   | meaning
  // IDLE    | waiting for fetch_go; PC may be loaded
  // FETCH   | memory read outstanding, timeout counter running
  // FAULT   | misaligned PC or timeout; held until reset
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic            irv_q, irv_d;
  logic            fault_q, fault_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cnt_inc;

  logic [31:0]     se16;
  logic [31:0]     br_tgt;
  logic [31:0]     jmp_tgt;
  logic [31:0]     ld_pc;

  assign se16    = {{16{ir_q[15]}}, ir_q[15:0]};
  assign br_tgt  = pc_q + {se16[29:0], 2'b00};
  assign jmp_tgt = {pc_q[31:28], ir_q[25:0], 2'b00};
  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    ld_pc = pc_q;
    case (PC_sel)
      2'b00:   ld_pc = br_tgt;
      2'b01:   ld_pc = jmp_tgt;
      2'b10:   ld_pc = PC_In;
      default: ld_pc = pc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    irv_d   = 1'b0;
    fault_d = fault_q;
    cnt_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (PC_ld) pc_d = ld_pc;
        // alignment is judged on the PC as it will be after this edge
        if (fetch_go) begin
          if (pc_d[1:0] == 2'b00) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_FAULT;
            fault_d = 1'b1;
          end
        end
      end
      S_FETCH: begin
        if (im_ack) begin
          ir_d    = im_rdata;
          pc_d    = pc_q + 32'd4;
          irv_d   = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_inc == CW'(TIMEOUT)) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_FAULT: begin
        fault_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      irv_q   <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      irv_q   <= irv_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign im_cs    = (state_q == S_FETCH);
  assign im_rd    = (state_q == S_FETCH);
  assign im_addr  = pc_q;
  assign PC_Out   = pc_q;
  assign IR_Out   = ir_q;
  assign IR_valid = irv_q;
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign shamt    = ir_q[10:6];
  assign SE_16    = se16;
  assign busy     = (state_q != S_IDLE);
  assign fault    = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed vector table,
// multi-cycle corner sequences, and random stimulus against a reference model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          TO     = 16;

  logic        clk = 1'b0;
  logic        reset, fetch_go, PC_ld, im_ack;
  logic [1:0]  PC_sel;
  logic [31:0] PC_In, im_rdata;
  logic        im_cs, im_rd, IR_valid, busy, fault;
  logic [31:0] im_addr, PC_Out, IR_Out, SE_16;
  logic [4:0]  rs, rt, rd, shamt;

  int n_checks = 0;
  int n_err    = 0;

  instruction_fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .fetch_go(fetch_go), .PC_ld(PC_ld),
    .PC_sel(PC_sel), .PC_In(PC_In), .im_ack(im_ack), .im_rdata(im_rdata),
    .im_cs(im_cs), .im_rd(im_rd), .im_addr(im_addr), .PC_Out(PC_Out),
    .IR_Out(IR_Out), .IR_valid(IR_valid), .rs(rs), .rt(rt), .rd(rd),
    .shamt(shamt), .SE_16(SE_16), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "watchdog");
  end

  // reference model: mode 0=idle 1=fetching 2=faulted
  logic [31:0] m_pc = 0, m_ir = 0;
  logic        m_irv = 0, m_fault = 0;
  int          m_mode = 0, m_wait = 0;

  function automatic logic [31:0] offset16(input logic [31:0] ir);
    int v;
    v = int'(ir[15:0]);
    if (v >= 32768) v = v - 65536;
    return 32'(v);
  endfunction

  function automatic logic [31:0] target(input logic [1:0] sel);
    case (sel)
      2'd0:    return m_pc + offset16(m_ir) * 4;
      2'd1:    return (m_pc & 32'hF000_0000) | ((m_ir & 32'h03FF_FFFF) * 4);
      2'd2:    return PC_In;
      default: return m_pc;
    endcase
  endfunction

  task automatic model_step();
    logic [31:0] np;
    if (reset) begin
      m_pc = RST_PC; m_ir = 0; m_irv = 0; m_fault = 0; m_mode = 0; m_wait = 0;
    end else begin
      m_irv = 0;
      if (m_mode == 0) begin
        np = PC_ld ? target(PC_sel) : m_pc;
        m_pc = np;
        if (fetch_go) begin
          if (np % 4 == 0) begin m_mode = 1; m_wait = 0; end
          else begin m_mode = 2; m_fault = 1; end
        end
      end else if (m_mode == 1) begin
        m_wait++;
        if (im_ack) begin
          m_ir = im_rdata; m_pc = m_pc + 4; m_irv = 1; m_mode = 0;
        end else if (m_wait == TO) begin
          m_mode = 2; m_fault = 1;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic quiet();
    reset = 0; fetch_go = 0; PC_ld = 0; PC_sel = 2'b11; PC_In = 0; im_ack = 0; im_rdata = 0;
  endtask

  task automatic do_reset();
    quiet(); reset = 1; cycle(); reset = 0;
  endtask

  task automatic check_model();
    chk("rnd_pc", PC_Out, m_pc);
    chk("rnd_addr", im_addr, m_pc);
    chk("rnd_ir", IR_Out, m_ir);
    chk("rnd_irv", IR_valid, m_irv);
    chk("rnd_busy", busy, m_mode != 0);
    chk("rnd_fault", fault, m_fault);
    chk("rnd_cs", im_cs, m_mode == 1);
    chk("rnd_rd", im_rd, m_mode == 1);
    chk("rnd_rs", rs, (m_ir >> 21) & 31);
    chk("rnd_rt", rt, (m_ir >> 16) & 31);
    chk("rnd_rdf", rd, (m_ir >> 11) & 31);
    chk("rnd_shamt", shamt, (m_ir >> 6) & 31);
    chk("rnd_se16", SE_16, offset16(m_ir));
  endtask

  typedef struct {
    logic rst, go, ld; logic [1:0] sel; logic [31:0] pcin; logic ack; logic [31:0] rdata;
    logic [31:0] e_pc, e_ir; logic e_irv, e_busy, e_fault, e_cs;
  } vec_t;

  vec_t vecs[17];

  initial begin
    vecs[0]  = '{1'b1,1'b0,1'b0,2'd0,32'h0,1'b0,32'h0,        32'h0, 32'h0,        1'b0,1'b0,1'b0,1'b0};
    vecs[1]  = '{1'b0,1'b1,1'b0,2'd0,32'h0,1'b0,32'h0,        32'h0, 32'h0,        1'b0,1'b1,1'b0,1'b1};
    vecs[2]  = '{1'b0,1'b0,1'b0,2'd0,32'h0,1'b1,32'h012A4020, 32'h4, 32'h012A4020, 1'b1,1'b0,1'b0,1'b0};
    vecs[3]  = '{1'b0,1'b0,1'b0,2'd0,32'h0,1'b0,32'h0,        32'h4, 32'h012A4020, 1'b0,1'b0,1'b0,1'b0};
    vecs[4]  = '{1'b0,1'b0,1'b1,2'd2,32'h8,1'b0,32'h0,        32'h8, 32'h012A4020, 1'b0,1'b0,1'b0,1'b0};
    vecs[5]  = '{1'b0,1'b1,1'b0,2'd0,32'h0,1'b0,32'h0,        32'h8, 32'h012A4020, 1'b0,1'b1,1'b0,1'b1};
    vecs[6]  = '{1'b0,1'b0,1'b0,2'd0,32'h0,1'b1,32'h1000FFFF, 32'hC, 32'h1000FFFF, 1'b1,1'b0,1'b0,1'b0};
    vecs[7]  = '{1'b0,1'b0,1'b1,2'd2,32'h8,1'b0,32'h0,        32'h8, 32'h1000FFFF, 1'b0,1'b0,1'b0,1'b0};
    vecs[8]  = '{1'b0,1'b0,1'b1,2'd0,32'h0,1'b0,32'h0,        32'h4, 32'h1000FFFF, 1'b0,1'b0,1'b0,1'b0};
    vecs[9]  = '{1'b0,1'b1,1'b0,2'd0,32'h0,1'b0,32'h0,        32'h4, 32'h1000FFFF, 1'b0,1'b1,1'b0,1'b1};
    vecs[10] = '{1'b0,1'b0,1'b0,2'd0,32'h0,1'b1,32'h08000010, 32'h8, 32'h08000010, 1'b1,1'b0,1'b0,1'b0};
    vecs[11] = '{1'b0,1'b0,1'b1,2'd1,32'h0,1'b0,32'h0,        32'h40,32'h08000010, 1'b0,1'b0,1'b0,1'b0};
    vecs[12] = '{1'b0,1'b0,1'b1,2'd3,32'h0,1'b0,32'h0,        32'h40,32'h08000010, 1'b0,1'b0,1'b0,1'b0};
    vecs[13] = '{1'b0,1'b1,1'b1,2'd2,32'h6,1'b0,32'h0,        32'h6, 32'h08000010, 1'b0,1'b1,1'b1,1'b0};
    vecs[14] = '{1'b0,1'b1,1'b0,2'd0,32'h0,1'b1,32'h0,        32'h6, 32'h08000010, 1'b0,1'b1,1'b1,1'b0};
    vecs[15] = '{1'b0,1'b0,1'b1,2'd2,32'h0,1'b0,32'h0,        32'h6, 32'h08000010, 1'b0,1'b1,1'b1,1'b0};
    vecs[16] = '{1'b1,1'b0,1'b0,2'd0,32'h0,1'b0,32'h0,        32'h0, 32'h0,        1'b0,1'b0,1'b0,1'b0};

    quiet();
    reset = 1;

    // directed vector table
    for (int i = 0; i < 17; i++) begin
      reset = vecs[i].rst; fetch_go = vecs[i].go; PC_ld = vecs[i].ld; PC_sel = vecs[i].sel;
      PC_In = vecs[i].pcin; im_ack = vecs[i].ack; im_rdata = vecs[i].rdata;
      cycle();
      chk($sformatf("vec%0d_pc", i), PC_Out, vecs[i].e_pc);
      chk($sformatf("vec%0d_addr", i), im_addr, vecs[i].e_pc);
      chk($sformatf("vec%0d_ir", i), IR_Out, vecs[i].e_ir);
      chk($sformatf("vec%0d_irv", i), IR_valid, vecs[i].e_irv);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
      chk($sformatf("vec%0d_fault", i), fault, vecs[i].e_fault);
      chk($sformatf("vec%0d_cs", i), im_cs, vecs[i].e_cs);
      chk($sformatf("vec%0d_rd", i), im_rd, vecs[i].e_cs);
      if (i == 2) begin
        chk("basic_rs", rs, 32'd9);
        chk("basic_rt", rt, 32'd10);
        chk("basic_rd", rd, 32'd8);
        chk("basic_shamt", shamt, 32'd0);
      end
      if (i == 6) chk("branch_se16", SE_16, 32'hFFFF_FFFF);
    end

    // timeout: 16 FETCH edges without ack
    do_reset();
    fetch_go = 1; cycle(); fetch_go = 0;
    for (int k = 0; k < TO - 1; k++) cycle();
    chk("to_cs_before", im_cs, 1);
    chk("to_fault_before", fault, 0);
    cycle();
    chk("to_fault", fault, 1);
    chk("to_cs_after", im_cs, 0);
    chk("to_busy", busy, 1);
    fetch_go = 1; PC_ld = 1; PC_sel = 2'd2; PC_In = 32'h100; cycle(); quiet();
    chk("to_go_ignored_fault", fault, 1);
    chk("to_go_ignored_cs", im_cs, 0);
    chk("to_ld_ignored_pc", PC_Out, 0);

    // ack arriving on the 16th edge wins over the timeout
    do_reset();
    fetch_go = 1; cycle(); fetch_go = 0;
    for (int k = 0; k < TO - 1; k++) cycle();
    im_ack = 1; im_rdata = 32'hAABB_CCDC; cycle(); im_ack = 0;
    chk("ack16_fault", fault, 0);
    chk("ack16_irv", IR_valid, 1);
    chk("ack16_ir", IR_Out, 32'hAABB_CCDC);
    chk("ack16_pc", PC_Out, 32'h4);
    chk("ack16_busy", busy, 0);
    cycle();
    chk("ack16_irv_pulse", IR_valid, 0);

    // reset in the 3rd FETCH cycle with an ack pending
    do_reset();
    PC_ld = 1; PC_sel = 2'd2; PC_In = 32'h20; fetch_go = 1; cycle(); quiet();
    cycle(); cycle();
    chk("rmf_cs_cycle3", im_cs, 1);
    reset = 1; im_ack = 1; im_rdata = 32'hDEAD_BEEF; cycle();
    chk("rmf_pc", PC_Out, RST_PC);
    chk("rmf_ir", IR_Out, 0);
    chk("rmf_irv", IR_valid, 0);
    chk("rmf_cs", im_cs, 0);
    reset = 0; cycle(); im_ack = 0;
    chk("rmf_irv_after", IR_valid, 0);
    chk("rmf_ir_after", IR_Out, 0);

    // PC wrap; PC_ld during FETCH ignored
    PC_ld = 1; PC_sel = 2'd2; PC_In = 32'hFFFF_FFFC; cycle(); quiet();
    chk("wrap_load", PC_Out, 32'hFFFF_FFFC);
    fetch_go = 1; cycle(); fetch_go = 0;
    PC_ld = 1; PC_sel = 2'd2; PC_In = 32'h100; cycle(); quiet();
    chk("wrap_ld_ignored", PC_Out, 32'hFFFF_FFFC);
    chk("wrap_busy", busy, 1);
    im_ack = 1; im_rdata = 32'h1234_5678; cycle(); im_ack = 0;
    chk("wrap_pc", PC_Out, 32'h0);
    chk("wrap_irv", IR_valid, 1);

    // random stimulus against the reference model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      reset    = ($urandom_range(0, 59) == 0);
      fetch_go = ($urandom_range(0, 2) == 0);
      PC_ld    = ($urandom_range(0, 3) == 0);
      PC_sel   = 2'($urandom_range(0, 3));
      PC_In    = $urandom;
      if ($urandom_range(0, 9) != 0) PC_In[1:0] = 2'b00;
      im_ack   = ($urandom_range(0, 5) == 0);
      im_rdata = $urandom;
      cycle();
      check_model();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameters SHALL be RESET_PC, default 32'h0000_0000, the PC value after reset; and TIMEOUT, default 16, the maximum number of FETCH cycles allowed without im_ack.
REQ-002 The module SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  system clock, rising-edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 fetch_go  input  1  control-unit request to fetch at the current PC.
REQ-006 PC_ld  input  1  load the PC from the source chosen by PC_sel.
REQ-007 PC_sel  input  2  PC source: 00 branch target, 01 jump target, 10 PC_In, 11 hold.
REQ-008 PC_In  input  32  register-sourced PC, taken from the datapath RS output.
REQ-009 im_ack  input  1  instruction memory read data valid.
REQ-010 im_rdata  input  32  instruction memory read data.
REQ-011 im_cs, im_rd  output  1 each  memory chip-select and read strobe.
REQ-012 im_addr  output  32  memory address, equal to PC_Out.
REQ-013 PC_Out  output  32  current PC.
REQ-014 IR_Out  output  32  instruction register.
REQ-015 IR_valid  output  1  one-cycle pulse after the IR is updated.
REQ-016 rs, rt, rd, shamt  output  5 each  IR[25:21], IR[20:16], IR[15:11], IR[10:6].
REQ-017 SE_16  output  32  IR[15:0] sign-extended to 32 bits.
REQ-018 busy  output  1  high when the state is not IDLE.
REQ-019 fault  output  1  sticky fetch fault flag.

Function
REQ-020 The FSM SHALL have three states: IDLE, FETCH and FAULT.
REQ-021 IDLE: when fetch_go=1 and PC_Out[1:0]=00, the next state SHALL be FETCH; when fetch_go=1 and PC_Out[1:0]≠00, the next state SHALL be FAULT and no memory request SHALL be issued.
REQ-022 FETCH: im_cs and im_rd SHALL be 1 and the timeout counter SHALL increment each cycle; in all other states im_cs, im_rd and the counter SHALL be 0.
REQ-023 FETCH with im_ack=1 at an edge: IR SHALL load im_rdata, PC SHALL become PC+4 (mod 2^32), the counter SHALL clear, and the next state SHALL be IDLE.
REQ-024 IR_valid SHALL be registered and SHALL be high for exactly the one cycle that follows the IR load.
REQ-025 When the counter reaches TIMEOUT without an ack, the next state SHALL be FAULT and fault SHALL be set to 1; if im_ack arrives on that same edge, the ack SHALL win and the fetch SHALL complete normally.
REQ-026 FAULT SHALL be held until reset, with fetch_go and PC_ld ignored.
REQ-027 PC_ld SHALL be honored only in IDLE; in FETCH and FAULT it SHALL be ignored.
REQ-028 The branch target SHALL be PC + (SE_16 << 2), with 32-bit wrap.
REQ-029 The jump target SHALL be {PC[31:28], IR[25:0], 2'b00}.
REQ-030 PC_sel=11 SHALL leave the PC unchanged.
REQ-031 When PC_ld and fetch_go are both asserted in IDLE, the PC SHALL update on that edge and the fetch (and the alignment check) SHALL use the updated PC.
REQ-032 fetch_go SHALL be ignored while busy; no request is queued.
REQ-033 rs, rt, rd, shamt and SE_16 SHALL be combinational from the IR.
REQ-034 Minimum latency SHALL be: fetch_go sampled at edge N, im_ack sampled at edge N+1, IR valid and IR_valid high during cycle N+1..N+2.

Reset
REQ-035 On an edge with reset=1, regardless of state (including mid-FETCH), the block SHALL set PC to RESET_PC, IR to 0, state to IDLE, counter to 0, fault to 0 and IR_valid to 0.
REQ-036 While reset=1, im_cs and im_rd SHALL be 0 from the first clock edge onward.
REQ-037 A pending memory ack during reset SHALL be discarded.

Verification
REQ-038 Basic fetch: reset, then fetch_go with im_ack on the next cycle and im_rdata=32'h012A4020 -> IR_Out=32'h012A4020, PC_Out=4, rs=9, rt=10, rd=8, one IR_valid pulse.
REQ-039 Branch: IR=32'h1000FFFF and PC=8, then PC_ld with PC_sel=00 -> PC=4; jump with IR=32'h08000010 -> PC=32'h40.
REQ-040 Timeout: fetch_go with im_ack held at 0 for 16 cycles -> fault=1, state FAULT, im_cs=0; a later fetch_go is ignored; an ack arriving on the 16th edge completes without fault.
REQ-041 Misaligned: PC_ld with PC_sel=10 and PC_In=32'h6, plus fetch_go on the same edge -> PC=6, fault=1, im_cs never asserted.
REQ-042 Reset mid-fetch: reset asserted in the 3rd FETCH cycle, then im_ack -> PC=RESET_PC, IR=0, IR_valid stays 0.
REQ-043 PC wrap and PC_ld-in-FETCH ignore: PC=32'hFFFFFFFC fetch -> PC=0; PC_ld pulsed during FETCH -> PC unchanged by the PC_ld.
